crypt_iter_engine: RTL and testbench

- Sequential, parametrised successor to the combinational 5-stage 16-byte encrypt/decrypt datapath.
- Processes one 128-bit block (4x4 bytes) per transaction. Applies NUM_ROUNDS keyed rounds, one round per clock.
- Uses valid/ready handshakes on input and output, so it can sit between the host interface and the block buffer.
- Key length scales with round count; mode (encrypt/decrypt) is latched per block.

---
 rtl/crypt_pkg.sv | 58 +++++
 rtl/crypt_iter_engine_round.sv | 14 +
 rtl/crypt_iter_engine.sv | 88 ++++++++
 tb/tb_crypt_iter_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// Shared types, round constants and the keyed round functions of the
// iterative 16-byte block engine.
package crypt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte 0 lives in element 15 so the packed view matches the bus byte order.
  typedef logic [15:0][7:0] block_t;

  localparam logic [3:0][7:0] C = {8'hC3, 8'h3C, 8'hA5, 8'h5A};

  function automatic logic [3:0] byte_pos(input logic [1:0] row, input logic [1:0] col);
    return ~{row, col};
  endfunction

  function automatic logic [127:0] xor_const(input logic [127:0] s, input logic [1:0] k,
                                             input logic [7:0] r);
    return s ^ {16{C[k] ^ r}};
  endfunction

  // Row j moves by (j + k) mod 4; the 2-bit column arithmetic wraps for free.
  function automatic logic [127:0] rotate_rows(input logic [127:0] s, input logic [1:0] k,
                                               input logic left);
    block_t     src;
    block_t     dst;
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] n;
    logic [1:0] src_col;
    src = s;
    dst = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        row     = 2'(j);
        col     = 2'(i);
        n       = row + k;
        src_col = left ? col + n : col - n;
        dst[byte_pos(row, col)] = src[byte_pos(row, src_col)];
      end
    end
    return dst;
  endfunction

  function automatic logic [127:0] round_fwd(input logic [127:0] s, input logic [1:0] k,
                                             input logic [7:0] r);
    return rotate_rows(xor_const(s, k, r), k, 1'b1);
  endfunction

  function automatic logic [127:0] round_inv(input logic [127:0] s, input logic [1:0] k,
                                             input logic [7:0] r);
    return xor_const(rotate_rows(s, k, 1'b0), k, r);
  endfunction

endpackage

// File: rtl/crypt_iter_engine_round.sv
// Combinational single round: forward when dir=0, inverse when dir=1.
module crypt_round
  import crypt_pkg::*;
(
  input  logic [127:0] s,
  input  logic [1:0]   k,
  input  logic [7:0]   r,
  input  logic         dir,
  output logic [127:0] s_next
);

  assign s_next = dir ? round_inv(s, k, r) : round_fwd(s, k, r);

endmodule

// File: rtl/crypt_iter_engine.sv
// Iterative block engine: one keyed round per clock over a single 128-bit
// block, with valid/ready handshakes on both sides.
module crypt_iter_engine
  import crypt_pkg::*;
#(
  parameter int  NUM_ROUNDS = 5,
  localparam int KEY_W      = 2 * NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [KEY_W-1:0] in_key,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy
);

  localparam int                CNT_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           st_q;
  logic [127:0]     blk_q;
  logic [KEY_W-1:0] key_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       sub_k;
  logic [127:0]     blk_next;
  logic             last_round;

  // Subkey for round cnt_q sits MSB-first in the latched key.
  assign sub_k = 2'(key_q >> ((NUM_ROUNDS - 1 - int'(cnt_q)) * 2));

  crypt_round u_round (
    .s      (blk_q),
    .k      (sub_k),
    .r      (8'(cnt_q)),
    .dir    (mode_q),
    .s_next (blk_next)
  );

  // Decrypt counts down to 0; the counter stops on the last round rather than wrapping.
  assign last_round = mode_q ? (cnt_q == '0) : (cnt_q == LAST);

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q != IDLE);
  assign out_data  = out_valid ? blk_q : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      blk_q  <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            blk_q  <= in_data;
            key_q  <= in_key;
            mode_q <= in_mode;
            cnt_q  <= in_mode ? LAST : '0;
            st_q   <= RUN;
          end
        end
        RUN: begin
          blk_q <= blk_next;
          if (last_round) st_q <= DONE;
          else            cnt_q <= mode_q ? cnt_q - ONE : cnt_q + ONE;
        end
        DONE: begin
          if (out_ready) st_q <= IDLE;
        end
        // NOTE: an explicit default recovers from unused encodings instead of holding them.
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypt_iter_engine.sv
// Scoreboard bench for crypt_iter_engine with NUM_ROUNDS=1 and NUM_ROUNDS=5
// instances checked against a byte-level reference model.
module tb_crypt_iter_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid1, in_mode1, out_ready1, in_ready1, out_valid1, busy1;
  logic [127:0] in_data1, out_data1;
  logic [1:0]   in_key1;
  logic         in_valid5, in_mode5, out_ready5, in_ready5, out_valid5, busy5;
  logic [127:0] in_data5, out_data5;
  logic [9:0]   in_key5;

  crypt_iter_engine #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .in_key(in_key1), .in_mode(in_mode1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .busy(busy1)
  );

  crypt_iter_engine #(.NUM_ROUNDS(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .in_key(in_key5), .in_mode(in_mode5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_data(out_data5), .busy(busy5)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] q1[$];
  logic [127:0] q5[$];
  logic [7:0]   cmap[4] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: bytes in an array, rounds applied literally from the round rules.
  function automatic logic [127:0] model(input logic [127:0] p, input logic [31:0] key,
                                         input int nr, input bit dec);
    logic [7:0]   b[16];
    logic [7:0]   t[16];
    logic [7:0]   x;
    logic [127:0] res;
    int           r, k, n;
    for (int i = 0; i < 16; i++) b[i] = p[127-8*i -: 8];
    for (int step = 0; step < nr; step++) begin
      r = dec ? nr - 1 - step : step;
      k = int'((key >> (2 * (nr - 1 - r))) & 32'd3);
      x = cmap[k] ^ r[7:0];
      if (!dec) for (int i = 0; i < 16; i++) b[i] = b[i] ^ x;
      for (int j = 0; j < 4; j++) begin
        n = (j + k) % 4;
        for (int i = 0; i < 4; i++) begin
          if (!dec) t[4*j+i] = b[4*j+(i+n)%4];
          else      t[4*j+(i+n)%4] = b[4*j+i];
        end
      end
      b = t;
      if (dec) for (int i = 0; i < 16; i++) b[i] = b[i] ^ x;
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1 unexpected output: got %h expected none", out_data1);
      end else check("dut1 out_data", out_data1, q1.pop_front());
    end
    if (!rst && out_valid5 && out_ready5) begin
      if (q5.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut5 unexpected output: got %h expected none", out_data5);
      end else check("dut5 out_data", out_data5, q5.pop_front());
    end
  end

  function automatic logic rdy(input int which);
    return (which == 1) ? in_ready1 : in_ready5;
  endfunction

  function automatic logic ovld(input int which);
    return (which == 1) ? out_valid1 : out_valid5;
  endfunction

  // Called at posedge+1. Returns at posedge+1 of the first out_valid cycle;
  // lat counts the accept cycle as 1.
  task automatic send_block(input int which, input logic [127:0] d, input logic [9:0] key,
                            input bit mode, input logic [127:0] exp, input bit scramble,
                            output int lat);
    int waited = 0;
    if (which == 1) begin
      in_data1 = d; in_key1 = key[1:0]; in_mode1 = mode; in_valid1 = 1'b1;
    end else begin
      in_data5 = d; in_key5 = key; in_mode5 = mode; in_valid5 = 1'b1;
    end
    while (!rdy(which) && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 50) begin
      check("in_ready timeout", 128'(rdy(which)), 128'd1);
      in_valid1 = 1'b0; in_valid5 = 1'b0; lat = -1;
      return;
    end
    @(posedge clk);
    if (which == 1) q1.push_back(exp); else q5.push_back(exp);
    #1;
    in_valid1 = 1'b0; in_valid5 = 1'b0;
    if (scramble) begin
      if (which == 1) begin
        in_key1 = ~key[1:0]; in_mode1 = ~mode; in_data1 = {4{$urandom}};
      end else begin
        in_key5 = ~key; in_mode5 = ~mode; in_data5 = {4{$urandom}};
      end
    end
    lat = 1;
    while (!ovld(which) && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic rand_block(input int which, input bit scramble);
    logic [127:0] d;
    logic [9:0]   key;
    bit           mode;
    int           nr, lat;
    nr   = (which == 1) ? 1 : 5;
    d    = {$urandom, $urandom, $urandom, $urandom};
    key  = (which == 1) ? 10'($urandom_range(0, 3)) : 10'($urandom);
    mode = 1'($urandom);
    send_block(which, d, key, mode, model(d, 32'(key), nr, mode), scramble, lat);
    check($sformatf("dut%0d latency", which), 128'(lat), 128'(nr + 1));
    @(posedge clk); #1;
  endtask

  logic [127:0] p, ct, snap, d2;
  int           lat, pulses;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid1 = 1'b0; in_mode1 = 1'b0; in_key1 = '0; in_data1 = '0; out_ready1 = 1'b1;
    in_valid5 = 1'b1; in_mode5 = 1'b0; in_key5 = '0; in_data5 = {4{$urandom}}; out_ready5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready1", 128'(in_ready1), 128'd1);
    check("reset in_ready5", 128'(in_ready5), 128'd1);
    check("reset out_valid5", 128'(out_valid5), 128'd0);
    check("reset busy5 with in_valid", 128'(busy5), 128'd0);
    check("reset out_data5", out_data5, 128'd0);
    in_valid5 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed NUM_ROUNDS=1 vectors.
    send_block(1, 128'd0, 10'd0, 1'b0, {16{8'h5A}}, 1'b0, lat);
    check("nr1 key00 latency", 128'(lat), 128'd2);
    @(posedge clk); #1;
    send_block(1, 128'h000102030405060708090A0B0C0D0E0F, 10'd1, 1'b0,
               128'hA4A7A6A5A3A2A1A0AEADACAFA9A8ABAA, 1'b0, lat);
    check("nr1 key01 latency", 128'(lat), 128'd2);
    @(posedge clk); #1;

    // NUM_ROUNDS=5 round trip.
    p  = 128'h00112233445566778899AABBCCDDEEFF;
    ct = model(p, 32'h2C5, 5, 1'b0);
    send_block(5, p, 10'h2C5, 1'b0, ct, 1'b0, lat);
    check("nr5 encrypt latency", 128'(lat), 128'd6);
    n_tests++;
    if (out_data5 === p) begin
      n_fail++;
      $display("FAIL nr5 ciphertext differs: got %h expected anything else", out_data5);
    end
    @(posedge clk); #1;
    send_block(5, ct, 10'h2C5, 1'b1, p, 1'b0, lat);
    check("nr5 decrypt latency", 128'(lat), 128'd6);
    @(posedge clk); #1;

    // Randomized traffic on both instances.
    for (int i = 0; i < 12; i++) begin
      rand_block(1, 1'b0);
      rand_block(5, 1'b0);
    end

    // Backpressure: hold the result in DONE with a competing block offered.
    out_ready5 = 1'b0;
    p = {4{$urandom}};
    send_block(5, p, 10'h13A, 1'b0, model(p, 32'h13A, 5, 1'b0), 1'b0, lat);
    snap = out_data5;
    d2 = {$urandom, $urandom, $urandom, $urandom};
    in_data5 = d2; in_key5 = 10'h2F1; in_mode5 = 1'b1; in_valid5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp out_valid held", 128'(out_valid5), 128'd1);
      check("bp out_data stable", out_data5, snap);
      check("bp in_ready low", 128'(in_ready5), 128'd0);
      check("bp busy", 128'(busy5), 128'd1);
    end
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    check("post-handshake in_ready", 128'(in_ready5), 128'd1);
    check("post-handshake out_valid", 128'(out_valid5), 128'd0);
    @(posedge clk);
    q5.push_back(model(d2, 32'h2F1, 5, 1'b1));
    #1;
    in_valid5 = 1'b0;
    check("accept after handshake", 128'(busy5), 128'd1);
    lat = 1;
    while (!out_valid5 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check("bp second latency", 128'(lat), 128'd6);
    @(posedge clk); #1;

    // Reset during the second round cycle aborts the block.
    in_data5 = {4{$urandom}}; in_key5 = 10'($urandom); in_mode5 = 1'b0; in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort in_ready", 128'(in_ready5), 128'd1);
    check("abort busy", 128'(busy5), 128'd0);
    check("abort out_data", out_data5, 128'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid5) pulses++;
      @(posedge clk); #1;
    end
    check("abort no out_valid", 128'(pulses), 128'd0);
    rand_block(5, 1'b0);

    // Inputs changing while the block is in flight are ignored.
    for (int i = 0; i < 4; i++) begin
      rand_block(5, 1'b1);
      rand_block(1, 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("dut1 scoreboard drained", 128'(q1.size()), 128'd0);
    check("dut5 scoreboard drained", 128'(q5.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
